cmp_serial: RTL and testbench

CMP_SERIAL -- requirements
Module: cmp_serial

---
 rtl/cmp_serial.sv | 124 ++++++++++++
 tb/tb_cmp_serial.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_serial.sv
// Serial magnitude comparator: walks two operands MSB-first, one 2-bit slice per
// cycle, through a big/equal/small cascade and reports A>B, A==B or A<B.
module cmp_serial #(
    parameter int unsigned WIDTH      = 16,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             fo_big,
    output logic             fo_equal,
    output logic             fo_small
);

    localparam int unsigned NSL = WIDTH / 2;
    localparam int unsigned IW  = (NSL > 1) ? $clog2(NSL) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic             r_big;
    logic             r_eq;
    logic             r_small;
    logic             w_big;
    logic             w_eq;
    logic             w_small;
    logic [1:0]       w_sa;
    logic [1:0]       w_sb;
    logic             w_accept;
    logic             w_last;

    // Operands shift left each RUN cycle, so the current slice is always the top two bits.
    assign w_sa = r_a[WIDTH-1 -: 2];
    assign w_sb = r_b[WIDTH-1 -: 2];

    always_comb begin
        w_big   = r_big;
        w_eq    = r_eq;
        w_small = r_small;
        if (r_eq) begin
            if (w_sa[1] != w_sb[1]) begin
                w_big   = w_sa[1];
                w_small = w_sb[1];
                w_eq    = 1'b0;
            end else if (w_sa[0] != w_sb[0]) begin
                w_big   = w_sa[0];
                w_small = w_sb[0];
                w_eq    = 1'b0;
            end
        end
    end

    assign w_last   = (r_idx == '0) || (EARLY_EXIT && !w_eq);
    assign w_accept = start && (r_state != RUN);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = start ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_big    <= 1'b0;
            r_eq     <= 1'b1;
            r_small  <= 1'b0;
            fo_big   <= 1'b0;
            fo_equal <= 1'b0;
            fo_small <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_idx   <= IW'(NSL - 1);
            r_big   <= 1'b0;
            r_eq    <= 1'b1;
            r_small <= 1'b0;
        end else if (r_state == RUN) begin
            r_a     <= r_a << 2;
            r_b     <= r_b << 2;
            r_big   <= w_big;
            r_eq    <= w_eq;
            r_small <= w_small;
            // Results are loaded on the edge into DONE so they are already valid alongside done.
            if (w_last) begin
                fo_big   <= w_big;
                fo_equal <= w_eq;
                fo_small <= w_small;
            end else begin
                r_idx <= r_idx - IW'(1);
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);

endmodule

// File: tb/tb_cmp_serial.sv
// Scoreboard bench for cmp_serial: one full-scan and one early-exit instance
// share stimulus; expected flags, latency and busy length are queued per start.
module tb_cmp_serial;

    typedef struct {
        logic [2:0] flags;
        int         acc;
        int         lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [15:0] ia;
    logic [15:0] ib;
    logic        busy0, done0, big0, eq0, small0;
    logic        busy1, done1, big1, eq1, small1;

    int   n_checks;
    int   n_err;
    int   cyc;
    bit   in_reset;
    exp_t q0[$];
    exp_t q1[$];
    logic [2:0] last0;
    logic [2:0] last1;
    int   bcnt0;
    int   bcnt1;

    cmp_serial #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(i_start), .a(ia), .b(ib),
        .busy(busy0), .done(done0), .fo_big(big0), .fo_equal(eq0), .fo_small(small0)
    );

    cmp_serial #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(i_start), .a(ia), .b(ib),
        .busy(busy1), .done(done1), .fo_big(big1), .fo_equal(eq1), .fo_small(small1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Latency counts the accepting edge as edge 1, so a full 16-bit scan is 9.
    function automatic exp_t mk(input logic [15:0] xa, input logic [15:0] xb, input bit ee, input int acc);
        exp_t e;
        int   k;
        bit   found;
        logic [1:0] sa, sb;
        e.flags = (xa > xb) ? 3'b100 : (xa == xb) ? 3'b010 : 3'b001;
        k = 8;
        found = 1'b0;
        if (ee) begin
            for (int i = 7; i >= 0; i--) begin
                sa = xa[2*i +: 2];
                sb = xb[2*i +: 2];
                if (!found && sa != sb) begin
                    k = 8 - i;
                    found = 1'b1;
                end
            end
        end
        e.acc = acc;
        e.lat = k + 1;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!in_reset) begin
            if (done0) begin
                if (q0.size() == 0) begin
                    chk("d0_unexpected_done_qsize", q0.size(), 1);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    chk("d0_flags", {big0, eq0, small0}, e.flags);
                    chk("d0_latency", cyc - e.acc + 1, e.lat);
                    chk("d0_busy_len", bcnt0, e.lat - 1);
                    chk("d0_busy_in_done", busy0, 0);
                    last0 = e.flags;
                end
                bcnt0 = 0;
            end else if (busy0) begin
                bcnt0++;
                chk("d0_hold", {big0, eq0, small0}, last0);
            end else begin
                bcnt0 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!in_reset) begin
            if (done1) begin
                if (q1.size() == 0) begin
                    chk("d1_unexpected_done_qsize", q1.size(), 1);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("d1_flags", {big1, eq1, small1}, e.flags);
                    chk("d1_latency", cyc - e.acc + 1, e.lat);
                    chk("d1_busy_len", bcnt1, e.lat - 1);
                    last1 = e.flags;
                end
                bcnt1 = 0;
            end else if (busy1) begin
                bcnt1++;
                chk("d1_hold", {big1, eq1, small1}, last1);
            end else begin
                bcnt1 = 0;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_start(input logic [15:0] xa, input logic [15:0] xb, input bit push);
        ia = xa;
        ib = xb;
        i_start = 1'b1;
        if (push) begin
            q0.push_back(mk(xa, xb, 1'b0, cyc + 1));
            q1.push_back(mk(xa, xb, 1'b1, cyc + 1));
        end
        @(negedge clk);
        i_start = 1'b0;
        ia = 16'($urandom);
        ib = 16'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            chk("timeout_pending", q0.size() + q1.size(), 0);
            q0.delete();
            q1.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [15:0] ra, rb;
        n_checks = 0;
        n_err = 0;
        cyc = 0;
        in_reset = 1'b1;
        last0 = '0;
        last1 = '0;
        bcnt0 = 0;
        bcnt1 = 0;
        rst_n = 1'b0;
        i_start = 1'b0;
        ia = '0;
        ib = '0;
        repeat (3) @(negedge clk);
        chk("rst_state0", {busy0, done0, big0, eq0, small0}, 5'b0);
        chk("rst_state1", {busy1, done1, big1, eq1, small1}, 5'b0);
        rst_n = 1'b1;
        in_reset = 1'b0;
        @(negedge clk);

        do_start(16'h1234, 16'h1234, 1'b1);
        wait_idle();
        do_start(16'h0001, 16'h0002, 1'b1);
        wait_idle();
        do_start(16'h8000, 16'h7FFF, 1'b1);
        wait_idle();

        // Second start during RUN must be ignored.
        do_start(16'h0001, 16'h0001, 1'b1);
        repeat (2) @(negedge clk);
        do_start(16'hFFFF, 16'h0000, 1'b0);
        wait_idle();
        repeat (12) @(negedge clk);

        // Reset in the 4th RUN cycle aborts without a done pulse.
        do_start(16'hABCD, 16'hABCD, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        in_reset = 1'b1;
        q0.delete();
        q1.delete();
        @(negedge clk);
        chk("abort_state0", {busy0, done0, big0, eq0, small0}, 5'b0);
        chk("abort_state1", {busy1, done1, big1, eq1, small1}, 5'b0);
        rst_n = 1'b1;
        in_reset = 1'b0;
        last0 = '0;
        last1 = '0;
        repeat (12) @(negedge clk);
        do_start(16'd5, 16'd3, 1'b1);
        wait_idle();

        // Back-to-back: new start issued in the DONE cycle.
        do_start(16'h1234, 16'h1234, 1'b1);
        for (int i = 0; i < 20 && !done0; i++) @(negedge clk);
        chk("b2b_done_seen", done0, 1);
        do_start(16'd2, 16'd9, 1'b1);
        wait_idle();

        for (int n = 0; n < 10; n++) begin
            ra = 16'($urandom);
            case (n % 3)
                0: rb = ra;
                1: rb = ra ^ (16'h1 << (n % 16));
                default: rb = 16'($urandom);
            endcase
            do_start(ra, rb, 1'b1);
            wait_idle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got %0d expected 0", 1);
        $fatal(1, "timeout");
    end

endmodule
